// File: rtl/flow_quant.sv
// flow_quant: N-lane streaming quantiser for the JPEG datapath.
// Each lane multiplies a signed coefficient by an unsigned reciprocal, rounds half away from
// zero on a right shift by SHIFT and saturates to OW bits. The sideband and the data travel
// through a PIPE-deep pipeline that only advances on en=1 edges. Input-side framing checks
// drive a sticky err_frame, and an output-side counter tracks emitted blocks.
// Optional feature macro: FLOW_QUANT_ZCNT_EN adds out_zcnt, the count of zero coefficients
// in a block, presented on the out_eob beat.
module flow_quant #(
    parameter int unsigned N         = 2,
    parameter int unsigned DW        = 16,
    parameter int unsigned MW        = 12,
    parameter int unsigned OW        = 16,
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned PIPE      = 4,
    parameter int unsigned BLK_BEATS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N*MW-1:0] in_mult,
    input  logic            in_sob,
    input  logic            in_eob,
    input  logic            in_sof,
    output logic            out_valid,
    output logic [N*OW-1:0] out_data,
    output logic            out_sob,
    output logic            out_eob,
    output logic            out_sof,
    output logic [N-1:0]    out_sat,
    output logic [15:0]     out_blk_cnt,
`ifdef FLOW_QUANT_ZCNT_EN
    output logic [6:0]      out_zcnt,
`endif
    output logic            err_frame
);

    localparam int unsigned PW  = DW + MW + 1;
    localparam int unsigned BCW = $clog2(BLK_BEATS + 1);

    localparam logic [PW:0]        ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW:0]        HALF = (SHIFT == 0) ? '0 : (ONE << (SHIFT - 1));
    localparam logic signed [PW:0] MAXV = {{(PW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [PW:0] MINV = ~MAXV;

    localparam logic [BCW-1:0] LAST = BCW'(BLK_BEATS - 1);
    localparam logic [BCW-1:0] FULL = BCW'(BLK_BEATS);

    // Round half away from zero on magnitude, then clamp; returns {sat, value}.
    function automatic logic [OW:0] round_sat(input logic [PW-1:0] p);
        logic        neg;
        logic [PW:0] mag;
        logic [PW:0] r;
        neg = p[PW-1];
        mag = neg ? (~{1'b1, p} + ONE) : {1'b0, p};
        mag = (mag + HALF) >> SHIFT;
        r   = neg ? (~mag + ONE) : mag;
        if ($signed(r) > MAXV) return {1'b1, MAXV[OW-1:0]};
        if ($signed(r) < MINV) return {1'b1, MINV[OW-1:0]};
        return {1'b0, r[OW-1:0]};
    endfunction

    // Sideband shift chain; bit 0 is stage 1, bit PIPE-1 drives the outputs.
    logic [PIPE-1:0] v_q, sob_q, eob_q, sof_q;
    logic [N*DW-1:0] s1_data_q;
    logic [N*MW-1:0] s1_mult_q;

    // Stage 1 and sideband pipeline; sof only counts when it arrives with sob.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            sob_q     <= '0;
            eob_q     <= '0;
            sof_q     <= '0;
            s1_data_q <= '0;
            s1_mult_q <= '0;
        end else if (en) begin
            v_q       <= {v_q[PIPE-2:0], in_valid};
            sob_q     <= {sob_q[PIPE-2:0], in_valid & in_sob};
            eob_q     <= {eob_q[PIPE-2:0], in_valid & in_eob};
            sof_q     <= {sof_q[PIPE-2:0], in_valid & in_sof & in_sob};
            s1_data_q <= in_data;
            s1_mult_q <= in_mult;
        end
    end

    logic [N*PW-1:0] prod_c;
    logic [N*PW-1:0] rs_src;
    logic [N*OW-1:0] rs_data_c;
    logic [N-1:0]    rs_sat_c;

    // Per-lane signed x unsigned product, full width so it never overflows.
    always_comb begin
        prod_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            prod_c[i*PW +: PW] = PW'($signed(s1_data_q[i*DW +: DW]))
                               * PW'({1'b0, s1_mult_q[i*MW +: MW]});
        end
    end

    // Per-lane round and saturate of whichever product feeds the final arithmetic stage.
    always_comb begin
        logic [OW:0] t;
        t         = '0;
        rs_data_c = '0;
        rs_sat_c  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            t                     = round_sat(rs_src[i*PW +: PW]);
            rs_sat_c[i]           = t[OW];
            rs_data_c[i*OW +: OW] = t[OW-1:0];
        end
    end

    if (PIPE == 2) begin : g_merged
        logic [N*OW-1:0] d_q;
        logic [N-1:0]    s_q;

        assign rs_src = prod_c;

        // Multiply, round and saturate collapse into one stage.
        always_ff @(posedge clk) begin
            if (rst) begin
                d_q <= '0;
                s_q <= '0;
            end else if (en) begin
                d_q <= rs_data_c;
                s_q <= rs_sat_c;
            end
        end

        assign out_data = d_q;
        assign out_sat  = s_q;
    end else begin : g_split
        logic [N*PW-1:0]                p_q;
        logic [PIPE-3:0][N*OW-1:0]      d_q;
        logic [PIPE-3:0][N-1:0]         s_q;

        assign rs_src = p_q;

        // Product register, round/saturate register, then plain delay stages.
        always_ff @(posedge clk) begin
            if (rst) begin
                p_q <= '0;
                d_q <= '0;
                s_q <= '0;
            end else if (en) begin
                p_q    <= prod_c;
                d_q[0] <= rs_data_c;
                s_q[0] <= rs_sat_c;
                for (int unsigned k = 1; k < PIPE - 2; k++) begin
                    d_q[k] <= d_q[k-1];
                    s_q[k] <= s_q[k-1];
                end
            end
        end

        assign out_data = d_q[PIPE-3];
        assign out_sat  = s_q[PIPE-3];
    end

    assign out_valid = v_q[PIPE-1];
    assign out_sob   = sob_q[PIPE-1];
    assign out_eob   = eob_q[PIPE-1];
    assign out_sof   = sof_q[PIPE-1];

    // Block counter is computed from the beat entering the last stage so that the
    // value shown alongside an out_eob beat already includes that block.
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (v_q[PIPE-2]) begin
            blk_cnt_d = (sof_q[PIPE-2] ? 16'd0 : blk_cnt_q) + {15'd0, eob_q[PIPE-2]};
        end
    end

    // Framing checker: idx is this beat's position in its block.
    logic [BCW-1:0] bc_q, bc_d, idx;
    logic           err_q, err_d;

    always_comb begin
        bc_d  = bc_q;
        err_d = err_q;
        idx   = in_sob ? '0 : bc_q;
        if (in_valid) begin
            if (in_sob && bc_q != '0)    err_d = 1'b1;
            if (!in_sob && bc_q == '0)   err_d = 1'b1;
            if (in_sof && !in_sob)       err_d = 1'b1;
            // eob must land exactly on the last beat, and the last beat must carry eob.
            if (in_eob != (idx == LAST)) err_d = 1'b1;
            if (in_eob) begin
                bc_d = '0;
            end else if (idx != FULL) begin
                bc_d = idx + BCW'(1);
            end
        end
    end

    // Counter and checker state, frozen while en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
            bc_q      <= '0;
            err_q     <= 1'b0;
        end else if (en) begin
            blk_cnt_q <= blk_cnt_d;
            bc_q      <= bc_d;
            err_q     <= err_d;
        end
    end

    assign out_blk_cnt = blk_cnt_q;
    assign err_frame   = err_q;

`ifdef FLOW_QUANT_ZCNT_EN
    logic [6:0] zacc_q, zacc_d, zsum_c;

    // Zero count including the current output beat; restarts on out_sob.
    always_comb begin
        zsum_c = out_sob ? 7'd0 : zacc_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (out_data[i*OW +: OW] == '0) zsum_c = zsum_c + 7'd1;
        end
        zacc_d   = out_valid ? zsum_c : zacc_q;
        out_zcnt = (out_valid && out_eob) ? zsum_c : 7'd0;
    end

    // Zero-count accumulator, advanced once per emitted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            zacc_q <= '0;
        end else if (en) begin
            zacc_q <= zacc_d;
        end
    end
`endif

endmodule

// File: tb/tb_flow_quant.sv
// Directed self-checking bench for flow_quant with default parameters
// (N=2, DW=16, MW=12, OW=16, SHIFT=8, PIPE=4, BLK_BEATS=32).
module tb_flow_quant;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic [31:0] in_data;
    logic [23:0] in_mult;
    logic        in_sob;
    logic        in_eob;
    logic        in_sof;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_sob;
    logic        out_eob;
    logic        out_sof;
    logic [1:0]  out_sat;
    logic [15:0] out_blk_cnt;
    logic        err_frame;
`ifdef FLOW_QUANT_ZCNT_EN
    logic [6:0]  out_zcnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flow_quant dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_mult     (in_mult),
        .in_sob      (in_sob),
        .in_eob      (in_eob),
        .in_sof      (in_sof),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_sob     (out_sob),
        .out_eob     (out_eob),
        .out_sof     (out_sof),
        .out_sat     (out_sat),
        .out_blk_cnt (out_blk_cnt),
`ifdef FLOW_QUANT_ZCNT_EN
        .out_zcnt    (out_zcnt),
`endif
        .err_frame   (err_frame)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
        in_mult  = '0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drive(input int d0, input int m0, input int d1, input int m1,
                         input logic sob, input logic eob, input logic sof);
        in_valid = 1'b1;
        in_data  = {16'(d1), 16'(d0)};
        in_mult  = {12'(m1), 12'(m0)};
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
    endtask

    task automatic do_reset();
        idle();
        en  = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        en = 1'b1;
        drive(100, 128, 200, 128, 1'b1, 1'b0, 1'b1);
        step();
        drive(5, 128, 6, 128, 1'b0, 1'b0, 1'b1);
        step();
        step();
        // Reset with en=0 while beats are in flight.
        idle();
        en  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out_sob !== 1'b0) begin failures++; $display("FAIL reset_sob got=%b want=0", out_sob); end
        checks++; if (out_eob !== 1'b0) begin failures++; $display("FAIL reset_eob got=%b want=0", out_eob); end
        checks++; if (out_sof !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b want=0", out_sof); end
        checks++; if (out_sat !== 2'b00) begin failures++; $display("FAIL reset_sat got=%b want=00", out_sat); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h want=0", out_data); end
        checks++; if (out_blk_cnt !== 16'h0) begin failures++; $display("FAIL reset_blk_cnt got=%0d want=0", out_blk_cnt); end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_frame); end
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_discard got=%b want=0", out_valid); end
    endtask

    task automatic test_rounding();
        int d0 [6] = '{100, 3, -3, -1, 1, -1};
        int m0 [6] = '{128, 128, 128, 127, 128, 128};
        int e0 [6] = '{50, 2, -2, 0, 1, -1};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(d0[i], m0[i], -100, 128, 1'b0, 1'b0, 1'b0);
            step();
            idle();
            step();
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++; $display("FAIL round_early[%0d] valid got=%b want=0", i, out_valid);
            end
            step();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL round_valid[%0d] got=%b want=1", i, out_valid);
            end
            checks++;
            if (out_data[15:0] !== 16'(e0[i])) begin
                failures++;
                $display("FAIL round_lane0[%0d] got=%0d want=%0d", i, $signed(out_data[15:0]), e0[i]);
            end
            checks++;
            if (out_data[31:16] !== 16'(-50)) begin
                failures++;
                $display("FAIL round_lane1[%0d] got=%0d want=-50", i, $signed(out_data[31:16]));
            end
            checks++;
            if (out_sat !== 2'b00) begin
                failures++; $display("FAIL round_sat[%0d] got=%b want=00", i, out_sat);
            end
        end
    endtask

    task automatic test_saturation();
        int d0 [3] = '{32767, -32768, 32767};
        int m0 [3] = '{4095, 4095, 256};
        int d1 [3] = '{5, -7, -32768};
        int m1 [3] = '{256, 256, 256};
        int e0 [3] = '{32767, -32768, 32767};
        int e1 [3] = '{5, -7, -32768};
        logic [1:0] es [3] = '{2'b01, 2'b01, 2'b00};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(d0[i], m0[i], d1[i], m1[i], 1'b0, 1'b0, 1'b0);
            step();
            idle();
            step();
            step();
            step();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++; $display("FAIL sat_valid[%0d] got=%b want=1", i, out_valid);
            end
            checks++;
            if (out_data[15:0] !== 16'(e0[i])) begin
                failures++;
                $display("FAIL sat_lane0[%0d] got=%0d want=%0d", i, $signed(out_data[15:0]), e0[i]);
            end
            checks++;
            if (out_data[31:16] !== 16'(e1[i])) begin
                failures++;
                $display("FAIL sat_lane1[%0d] got=%0d want=%0d", i, $signed(out_data[31:16]), e1[i]);
            end
            checks++;
            if (out_sat !== es[i]) begin
                failures++; $display("FAIL sat_flag[%0d] got=%b want=%b", i, out_sat, es[i]);
            end
        end
    endtask

    task automatic test_stall();
        int   beat_in  = 0;
        int   beat_out = 0;
        int   en_edges = 0;
        int   lat      = -1;
        logic e;
        do_reset();
        for (int cyc = 0; cyc < 2000 && beat_out < 32; cyc++) begin
            if (beat_in < 32) begin
                drive(beat_in * 37 - 500, 256, beat_in, 512,
                      beat_in == 0, beat_in == 31, 1'b0);
            end else begin
                idle();
            end
            e  = 1'($urandom_range(0, 1));
            en = e;
            step();
            if (e) begin
                en_edges++;
                if (beat_in < 32) beat_in++;
                if (out_valid === 1'b1) begin
                    if (beat_out == 0) lat = en_edges;
                    checks++;
                    if (out_data !== {16'(2 * beat_out), 16'(beat_out * 37 - 500)}) begin
                        failures++;
                        $display("FAIL stall_data[%0d] got=%h want=%h", beat_out, out_data,
                                 {16'(2 * beat_out), 16'(beat_out * 37 - 500)});
                    end
                    checks++;
                    if ({out_sob, out_eob} !== {beat_out == 0, beat_out == 31}) begin
                        failures++;
                        $display("FAIL stall_sideband[%0d] got=%b%b want=%b%b", beat_out,
                                 out_sob, out_eob, beat_out == 0, beat_out == 31);
                    end
                    checks++;
                    if (out_blk_cnt !== ((beat_out == 31) ? 16'd1 : 16'd0)) begin
                        failures++;
                        $display("FAIL stall_blk_cnt[%0d] got=%0d want=%0d", beat_out,
                                 out_blk_cnt, (beat_out == 31) ? 1 : 0);
                    end
                    beat_out++;
                end
            end
        end
        en = 1'b1;
        checks++; if (beat_out != 32) begin failures++; $display("FAIL stall_count got=%0d want=32", beat_out); end
        checks++; if (lat != 4) begin failures++; $display("FAIL stall_latency got=%0d want=4", lat); end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL stall_err got=%b want=0", err_frame); end
    endtask

    task automatic test_framing();
        // Early eob on beat 20.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(k, 256, k, 256, k == 0, 1'b0, 1'b0);
            step();
        end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL frame_pre_eob got=%b want=0", err_frame); end
        drive(20, 256, 20, 256, 1'b0, 1'b1, 1'b0);
        step();
        checks++; if (err_frame !== 1'b1) begin failures++; $display("FAIL frame_early_eob got=%b want=1", err_frame); end
        idle();
        for (int k = 0; k < 4; k++) step();
        checks++; if (err_frame !== 1'b1) begin failures++; $display("FAIL frame_sticky got=%b want=1", err_frame); end
        do_reset();
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL frame_reset got=%b want=0", err_frame); end

        // New sob while bc=5.
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(k, 256, k, 256, k == 0, 1'b0, 1'b0);
            step();
        end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL frame_pre_sob got=%b want=0", err_frame); end
        drive(9, 256, 9, 256, 1'b1, 1'b0, 1'b0);
        step();
        checks++; if (err_frame !== 1'b1) begin failures++; $display("FAIL frame_sob_bc5 got=%b want=1", err_frame); end

        // Beat 31 without eob.
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 31; k++) begin
            drive(k, 256, k, 256, k == 0, 1'b0, 1'b0);
            step();
        end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL frame_pre_overrun got=%b want=0", err_frame); end
        drive(31, 256, 31, 256, 1'b0, 1'b0, 1'b0);
        step();
        checks++; if (err_frame !== 1'b1) begin failures++; $display("FAIL frame_overrun got=%b want=1", err_frame); end

        // sof without sob.
        do_reset();
        en = 1'b1;
        drive(7, 256, 7, 256, 1'b0, 1'b0, 1'b1);
        step();
        checks++; if (err_frame !== 1'b1) begin failures++; $display("FAIL frame_sof_nosob got=%b want=1", err_frame); end
        idle();
        step();
        step();
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL frame_sof_valid got=%b want=1", out_valid); end
        checks++; if (out_sof !== 1'b0) begin failures++; $display("FAIL frame_sof_forced got=%b want=0", out_sof); end
    endtask

    task automatic test_frame_count();
        int exp_cnt [4] = '{1, 2, 3, 1};
        int neob = 0;
        int nsof = 0;
        do_reset();
        en = 1'b1;
        for (int cyc = 0; cyc < 140; cyc++) begin
            if (cyc < 128) begin
                drive(cyc, 100, -cyc, 100, (cyc % 32) == 0, (cyc % 32) == 31,
                      (cyc == 0) || (cyc == 96));
            end else begin
                idle();
            end
            step();
            if (out_valid === 1'b1 && out_sof === 1'b1) begin
                checks++;
                if (out_blk_cnt !== 16'd0) begin
                    failures++; $display("FAIL fcnt_sof[%0d] got=%0d want=0", nsof, out_blk_cnt);
                end
                nsof++;
            end
            if (out_valid === 1'b1 && out_eob === 1'b1 && neob < 4) begin
                checks++;
                if (out_blk_cnt !== 16'(exp_cnt[neob])) begin
                    failures++;
                    $display("FAIL fcnt_eob[%0d] got=%0d want=%0d", neob, out_blk_cnt, exp_cnt[neob]);
                end
                neob++;
            end
        end
        checks++; if (neob != 4) begin failures++; $display("FAIL fcnt_blocks got=%0d want=4", neob); end
        checks++; if (nsof != 2) begin failures++; $display("FAIL fcnt_sofs got=%0d want=2", nsof); end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL fcnt_err got=%b want=0", err_frame); end
    endtask

    task automatic test_reset_midblock();
        logic seen = 1'b0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(0, 256, 0, 256, k == 0, 1'b0, k == 0);
            step();
        end
        drive(0, 256, 0, 256, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b want=0", seen); end
        checks++; if (out_blk_cnt !== 16'd0) begin failures++; $display("FAIL midrst_blk_cnt got=%0d want=0", out_blk_cnt); end
        checks++; if (err_frame !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b want=0", err_frame); end
`ifdef FLOW_QUANT_ZCNT_EN
        checks++; if (out_zcnt !== 7'd0) begin failures++; $display("FAIL midrst_zcnt got=%0d want=0", out_zcnt); end
`endif
    endtask

`ifdef FLOW_QUANT_ZCNT_EN
    task automatic test_zcnt();
        int exp_z [2] = '{64, 54};
        int neob = 0;
        int b;
        do_reset();
        en = 1'b1;
        for (int cyc = 0; cyc < 72; cyc++) begin
            if (cyc < 64) begin
                b = cyc % 32;
                // Second block: lane 0 nonzero on its first 10 beats.
                drive((cyc >= 32 && b < 10) ? 1000 : 0, 256, 0, 256, b == 0, b == 31, cyc == 0);
            end else begin
                idle();
            end
            step();
            if (out_valid === 1'b1 && out_eob !== 1'b1 && out_sob === 1'b1) begin
                checks++;
                if (out_zcnt !== 7'd0) begin
                    failures++; $display("FAIL zcnt_sob got=%0d want=0", out_zcnt);
                end
            end
            if (out_valid === 1'b1 && out_eob === 1'b1 && neob < 2) begin
                checks++;
                if (out_zcnt !== 7'(exp_z[neob])) begin
                    failures++;
                    $display("FAIL zcnt_eob[%0d] got=%0d want=%0d", neob, out_zcnt, exp_z[neob]);
                end
                neob++;
            end
        end
        checks++; if (neob != 2) begin failures++; $display("FAIL zcnt_blocks got=%0d want=2", neob); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        idle();
        test_reset();
        test_rounding();
        test_saturation();
        test_stall();
        test_framing();
        test_frame_count();
`ifdef FLOW_QUANT_ZCNT_EN
        test_zcnt();
`endif
        test_reset_midblock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
